// File: rtl/descale_ctrl_pkg.sv
// rtl/descale_ctrl_pkg.sv - shared types and constants for the descale dispatch controller
package descale_ctrl_pkg;
   localparam int MAX_INFLIGHT_DEF = 8;
   localparam int TAG_W            = 8;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   typedef struct packed {
      logic             owner;
      logic [TAG_W-1:0] tag;
   } owner_entry_t;
endpackage

// File: rtl/descale_dispatch_ctrl_owner_fifo.sv
// rtl/descale_dispatch_ctrl_owner_fifo.sv - in-order {owner, tag} record of issued operations
module owner_fifo
   import descale_ctrl_pkg::*;
#(
   parameter int DEPTH = MAX_INFLIGHT_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  owner_entry_t push_data,
   input  logic         pop,
   output owner_entry_t head,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

   owner_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/descale_dispatch_ctrl.sv
// rtl/descale_dispatch_ctrl.sv - two-requester round-robin issue and completion routing for the descale pipeline
module descale_dispatch_ctrl
   import descale_ctrl_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            req0,
   input  logic                            req1,
   input  logic [31:0]                     x0,
   input  logic [31:0]                     y0,
   input  logic [31:0]                     z0,
   input  logic [31:0]                     k0,
   input  logic [31:0]                     x1,
   input  logic [31:0]                     y1,
   input  logic [31:0]                     z1,
   input  logic [31:0]                     k1,
   input  logic [TAG_W-1:0]                tag0,
   input  logic [TAG_W-1:0]                tag1,
   input  logic                            natlog0,
   input  logic                            natlog1,
   output logic                            gnt0,
   output logic                            gnt1,
   input  logic                            hold,
   output logic [31:0]                     x_scale,
   output logic [31:0]                     y_scale,
   output logic [31:0]                     z_scale,
   output logic [31:0]                     k_in,
   output logic [TAG_W-1:0]                InsTagScaleOut,
   output logic                            NatLogFlagScaleOut,
   output logic                            ScaleValid,
   input  logic                            done,
   input  logic [TAG_W-1:0]                InsTagFinal,
   output logic                            done0,
   output logic                            done1,
   output logic [TAG_W-1:0]                tag_out,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight,
   output logic                            idle,
   output logic                            err
);
   localparam int CW = $clog2(MAX_INFLIGHT) + 1;
   localparam logic [CW-1:0] MAX_C = MAX_INFLIGHT[CW-1:0];

   state_t        state;
   logic          last_owner;
   logic          can_issue;
   logic          pick1;
   logic          gnt_any;
   logic          pop;
   logic [CW-1:0] inflight_nxt;
   owner_entry_t  push_data;
   owner_entry_t  head;
   logic          fifo_full;
   logic          fifo_empty;

   always_comb begin
      can_issue    = !reset && !hold && (inflight < MAX_C) && (state != S_DRAIN) && !fifo_full;
      // last_owner resets to 1 so requester 0 wins the first contested cycle.
      pick1        = req1 && (!req0 || !last_owner);
      gnt0         = can_issue && req0 && !pick1;
      gnt1         = can_issue && pick1;
      gnt_any      = gnt0 || gnt1;
      pop          = done && !fifo_empty;
      inflight_nxt = inflight + {{(CW-1){1'b0}}, gnt_any} - {{(CW-1){1'b0}}, pop};
      push_data    = '{owner: gnt1, tag: (gnt1 ? tag1 : tag0)};
   end

   assign idle = (state == S_IDLE);

   owner_fifo #(.DEPTH(MAX_INFLIGHT)) u_owner_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (gnt_any),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= S_IDLE;
         last_owner         <= 1'b1;
         inflight           <= '0;
         ScaleValid         <= 1'b0;
         x_scale            <= '0;
         y_scale            <= '0;
         z_scale            <= '0;
         k_in               <= '0;
         InsTagScaleOut     <= '0;
         NatLogFlagScaleOut <= 1'b0;
         done0              <= 1'b0;
         done1              <= 1'b0;
         tag_out            <= '0;
         err                <= 1'b0;
      end else begin
         ScaleValid <= gnt_any;
         inflight   <= inflight_nxt;
         if (gnt_any) begin
            last_owner         <= gnt1;
            x_scale            <= gnt1 ? x1 : x0;
            y_scale            <= gnt1 ? y1 : y0;
            z_scale            <= gnt1 ? z1 : z0;
            k_in               <= gnt1 ? k1 : k0;
            InsTagScaleOut     <= push_data.tag;
            NatLogFlagScaleOut <= gnt1 ? natlog1 : natlog0;
         end
         done0 <= pop && !head.owner;
         done1 <= pop && head.owner;
         if (pop) tag_out <= InsTagFinal;
         // A completion with nothing outstanding, or carrying the wrong tag, is a protocol error.
         if ((done && fifo_empty) || (pop && (InsTagFinal != head.tag))) err <= 1'b1;
         case (state)
            S_IDLE:  if (gnt_any) state <= S_RUN;
            S_RUN: begin
               if (inflight_nxt == '0) state <= S_IDLE;
               else if (hold)          state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (inflight_nxt == '0) state <= S_IDLE;
               else if (!hold)         state <= S_RUN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_descale_dispatch_ctrl.sv
// tb/tb_descale_dispatch_ctrl.sv - directed self-checking bench for descale_dispatch_ctrl
module tb_descale_dispatch_ctrl;
   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1, hold, done;
   logic [31:0] x0, y0, z0, k0, x1, y1, z1, k1;
   logic [7:0]  tag0, tag1, InsTagFinal;
   logic        natlog0, natlog1;
   logic        gnt0, gnt1, ScaleValid, NatLogFlagScaleOut;
   logic [31:0] x_scale, y_scale, z_scale, k_in;
   logic [7:0]  InsTagScaleOut, tag_out;
   logic        done0, done1, idle, err;
   logic [3:0]  inflight;

   int vectors = 0;
   int miscompares = 0;

   descale_dispatch_ctrl #(.MAX_INFLIGHT(8)) dut (
      .clock(clock), .reset(reset), .req0(req0), .req1(req1),
      .x0(x0), .y0(y0), .z0(z0), .k0(k0), .x1(x1), .y1(y1), .z1(z1), .k1(k1),
      .tag0(tag0), .tag1(tag1), .natlog0(natlog0), .natlog1(natlog1),
      .gnt0(gnt0), .gnt1(gnt1), .hold(hold),
      .x_scale(x_scale), .y_scale(y_scale), .z_scale(z_scale), .k_in(k_in),
      .InsTagScaleOut(InsTagScaleOut), .NatLogFlagScaleOut(NatLogFlagScaleOut),
      .ScaleValid(ScaleValid), .done(done), .InsTagFinal(InsTagFinal),
      .done0(done0), .done1(done1), .tag_out(tag_out),
      .inflight(inflight), .idle(idle), .err(err)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req0 = 0; req1 = 0; hold = 0; done = 0;
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      req0 = 1; req1 = 0; hold = 0; done = 0;
      reset = 1;
      step(); step();
      #1;
      vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %b exp 0", gnt0); end
      vectors++; if (ScaleValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", ScaleValid); end
      vectors++; if (inflight !== 4'd0) begin miscompares++; $display("FAIL reset_inflight: got %0d exp 0", inflight); end
      vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b exp 1", idle); end
      vectors++; if ({err, done0, done1, tag_out, x_scale, k_in} !== '0) begin miscompares++; $display("FAIL reset_regs: got nonzero err/done/tag/operands"); end
      req0 = 0;
      reset = 0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1; x0 = 32'h0000_1234; y0 = 32'h0000_5678; z0 = 32'h9abc_0000; k0 = 32'h0000_0007;
      tag0 = 8'h11; natlog0 = 1;
      #1;
      vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b exp 10", {gnt0, gnt1}); end
      step();                                       // T+1
      req0 = 0; x0 = 32'hdead_beef;
      vectors++; if (ScaleValid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b exp 1", ScaleValid); end
      vectors++; if ({x_scale, y_scale, z_scale, k_in} !== {32'h0000_1234, 32'h0000_5678, 32'h9abc_0000, 32'h0000_0007}) begin miscompares++; $display("FAIL single_operands: got %h %h %h %h", x_scale, y_scale, z_scale, k_in); end
      vectors++; if ({InsTagScaleOut, NatLogFlagScaleOut} !== {8'h11, 1'b1}) begin miscompares++; $display("FAIL single_tag: got %h/%b exp 11/1", InsTagScaleOut, NatLogFlagScaleOut); end
      vectors++; if ({inflight, idle} !== {4'd1, 1'b0}) begin miscompares++; $display("FAIL single_busy: got inflight %0d idle %b exp 1/0", inflight, idle); end
      step();                                       // T+2
      vectors++; if ({ScaleValid, x_scale} !== {1'b0, 32'h0000_1234}) begin miscompares++; $display("FAIL single_hold_operands: got %b/%h exp 0/00001234", ScaleValid, x_scale); end
      step(); step(); step();                       // T+5
      done = 1; InsTagFinal = 8'h11;
      step();                                       // T+6
      done = 0;
      vectors++; if ({done0, done1, tag_out} !== {1'b1, 1'b0, 8'h11}) begin miscompares++; $display("FAIL single_done: got %b%b tag %h exp 10 tag 11", done0, done1, tag_out); end
      step();                                       // T+7
      vectors++; if ({done0, idle, inflight, err} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin miscompares++; $display("FAIL single_idle: got done0 %b idle %b inflight %0d err %b", done0, idle, inflight, err); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_tag;
      do_reset();
      req0 = 1; req1 = 1; tag0 = 8'hA0; tag1 = 8'hB1; x1 = 32'h1111_0001;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_grant%0d: got %b", i, {gnt0, gnt1}); end
         step();
      end
      req0 = 0; req1 = 0;
      vectors++; if ({inflight, x_scale, InsTagScaleOut} !== {4'd4, 32'h1111_0001, 8'hB1}) begin miscompares++; $display("FAIL rr_issue: got %0d %h %h", inflight, x_scale, InsTagScaleOut); end
      for (int j = 0; j < 4; j++) begin
         exp_tag = (j % 2 == 0) ? 8'hA0 : 8'hB1;
         done = 1; InsTagFinal = exp_tag;
         step();
         vectors++; if ({done0, done1, tag_out} !== {(j % 2 == 0), (j % 2 == 1), exp_tag}) begin miscompares++; $display("FAIL rr_route%0d: got %b%b tag %h exp tag %h", j, done0, done1, tag_out, exp_tag); end
      end
      done = 0;
      step();
      vectors++; if ({inflight, err, idle} !== {4'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL rr_end: got inflight %0d err %b idle %b", inflight, err, idle); end
   endtask

   task automatic test_full();
      do_reset();
      req0 = 1; tag0 = 8'h20;
      for (int i = 0; i < 8; i++) begin
         #1;
         vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL full_fill%0d: got %b exp 1", i, gnt0); end
         step();
      end
      #1;                                           // cycle 8
      vectors++; if ({inflight, gnt0} !== {4'd8, 1'b0}) begin miscompares++; $display("FAIL full_at_max: got inflight %0d gnt0 %b exp 8/0", inflight, gnt0); end
      step();                                       // cycle 9
      done = 1; InsTagFinal = 8'h20;
      #1;
      vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL full_done_cycle_gnt: got %b exp 0", gnt0); end
      step();                                       // cycle 10
      done = 0;
      #1;
      vectors++; if ({inflight, done0, gnt0} !== {4'd7, 1'b1, 1'b1}) begin miscompares++; $display("FAIL full_slot_freed: got inflight %0d done0 %b gnt0 %b exp 7/1/1", inflight, done0, gnt0); end
      step();                                       // cycle 11
      #1;
      vectors++; if ({inflight, gnt0} !== {4'd8, 1'b0}) begin miscompares++; $display("FAIL full_refill: got inflight %0d gnt0 %b exp 8/0", inflight, gnt0); end
      req0 = 0;
      done = 1;
      for (int i = 0; i < 8; i++) step();
      done = 0;
      step();
      vectors++; if ({inflight, err, idle} !== {4'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL full_drain: got inflight %0d err %b idle %b", inflight, err, idle); end
   endtask

   task automatic test_drain();
      do_reset();
      req0 = 1; tag0 = 8'h30;
      step(); step();                               // two grants
      req0 = 0; hold = 1;
      step();                                       // RUN -> DRAIN
      req0 = 1;
      #1;
      vectors++; if ({gnt0, idle, inflight} !== {1'b0, 1'b0, 4'd2}) begin miscompares++; $display("FAIL drain_hold: got gnt0 %b idle %b inflight %0d exp 0/0/2", gnt0, idle, inflight); end
      step();
      hold = 0;
      #1;
      vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL drain_blocks: got %b exp 0", gnt0); end
      step();                                       // back in RUN
      #1;
      vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL drain_resume: got %b exp 1", gnt0); end
      step();
      req0 = 0; hold = 1;
      step();                                       // 3 in flight, DRAIN
      #1;
      vectors++; if ({inflight, gnt0, idle} !== {4'd3, 1'b0, 1'b0}) begin miscompares++; $display("FAIL drain_three: got inflight %0d gnt0 %b idle %b", inflight, gnt0, idle); end
      done = 1; InsTagFinal = 8'h30;
      step(); step(); step();
      done = 0;
      vectors++; if ({inflight, idle, err} !== {4'd0, 1'b1, 1'b0}) begin miscompares++; $display("FAIL drain_idle: got inflight %0d idle %b err %b exp 0/1/0", inflight, idle, err); end
      hold = 0;
   endtask

   task automatic test_err_empty();
      do_reset();
      done = 1; InsTagFinal = 8'h55;
      step();
      done = 0;
      vectors++; if ({err, done0, done1, inflight} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin miscompares++; $display("FAIL err_empty: got err %b done %b%b inflight %0d", err, done0, done1, inflight); end
      req1 = 1; tag1 = 8'h5A;
      step();
      req1 = 0;
      done = 1; InsTagFinal = 8'h5A;
      step();
      done = 0;
      step(); step();
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b exp 1", err); end
   endtask

   task automatic test_tag_mismatch();
      do_reset();
      req1 = 1; tag1 = 8'h66;
      step();
      req1 = 0;
      done = 1; InsTagFinal = 8'h67;
      step();
      done = 0;
      vectors++; if ({done1, done0, err, tag_out} !== {1'b1, 1'b0, 1'b1, 8'h67}) begin miscompares++; $display("FAIL tag_mismatch: got done1 %b done0 %b err %b tag %h", done1, done0, err, tag_out); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      req1 = 1; tag1 = 8'h44; x1 = 32'h4444_4444;
      step(); step(); step(); step();
      req1 = 0;
      vectors++; if (inflight !== 4'd4) begin miscompares++; $display("FAIL midop_inflight: got %0d exp 4", inflight); end
      reset = 1;
      step();
      reset = 0;
      vectors++; if ({inflight, ScaleValid, x_scale, InsTagScaleOut, done0, done1, err, idle} !== {4'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL midop_reset: got inflight %0d valid %b x %h idle %b err %b", inflight, ScaleValid, x_scale, idle, err); end
      done = 1; InsTagFinal = 8'h44;
      step();
      done = 0;
      vectors++; if ({err, done1} !== {1'b1, 1'b0}) begin miscompares++; $display("FAIL midop_stale: got err %b done1 %b exp 1/0", err, done1); end
   endtask

   initial begin
      reset = 1; req0 = 0; req1 = 0; hold = 0; done = 0; InsTagFinal = 0;
      x0 = 0; y0 = 0; z0 = 0; k0 = 0; x1 = 0; y1 = 0; z1 = 0; k1 = 0;
      tag0 = 0; tag1 = 0; natlog0 = 0; natlog1 = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_drain();
      test_err_empty();
      test_tag_mismatch();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/descale_dispatch_ctrl.md
DESCALE_DISPATCH_CTRL -- requirements
Module: descale_dispatch_ctrl

Interface
REQ-001 Parameter MAX_INFLIGHT, default 8, SHALL set the maximum number of operations outstanding in the descale pipeline (power of 2, 2..32).
REQ-002 clock  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0, req1  in  1 each  requester N holds an operation ready.
REQ-005 x0/y0/z0/k0, x1/y1/z1/k1  in  32 each  requester operands.
REQ-006 tag0, tag1  in  8 each  instruction tag; natlog0, natlog1  in  1 each  natural-log flag.
REQ-007 gnt0, gnt1  out  1 each  operation accepted this cycle.
REQ-008 hold  in  1  stop new issue while asserted.
REQ-009 x_scale, y_scale, z_scale, k_in  out  32 each  registered operands to the descale pipeline.
REQ-010 InsTagScaleOut  out  8; NatLogFlagScaleOut  out  1; ScaleValid  out  1  pipeline issue strobe.
REQ-011 done  in  1; InsTagFinal  in  8  pipeline completion and its tag.
REQ-012 done0, done1  out  1 each; tag_out  out  8  completion routed to its owner.
REQ-013 inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding count; idle  out  1; err  out  1  sticky protocol error.

Function
REQ-014 can_issue SHALL be: !hold && inflight < MAX_INFLIGHT && state != DRAIN.
REQ-015 gntN SHALL be combinational in cycle T: reqN && can_issue, and the arbiter selects it.
REQ-016 Arbitration SHALL be round-robin. With both requesting, the requester not granted last SHALL win. After reset, req0 SHALL win first.
REQ-017 At most one grant SHALL be issued per cycle.
REQ-018 A grant in cycle T SHALL drive ScaleValid=1 for exactly cycle T+1, with that requester's operands, tag and flag registered.
REQ-019 Pipeline operand outputs SHALL hold their last values when ScaleValid=0.
REQ-020 Each issue SHALL push the owner id (1 bit) into an in-order owner FIFO of depth MAX_INFLIGHT. Each done SHALL pop it.
REQ-021 inflight SHALL increment on issue (the ScaleValid cycle) and decrement on done. If both occur in the same cycle, it SHALL stay unchanged.
REQ-022 done at cycle T SHALL produce a one-cycle doneN at T+1 for the FIFO-head owner, with tag_out=InsTagFinal.
REQ-023 done with inflight==0 SHALL set err, SHALL NOT pop the FIFO and SHALL NOT assert doneN.
REQ-024 InsTagFinal differing from the tag recorded at issue for the head entry SHALL set err. Routing SHALL still follow the FIFO.
REQ-025 States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on any issue.
  - RUN -> DRAIN when hold=1 and inflight>0.
  - RUN -> IDLE when inflight reaches 0 with no issue.
  - DRAIN -> IDLE when inflight reaches 0.
  - DRAIN -> RUN when hold deasserts with inflight>0.
REQ-026 idle SHALL be 1 only in IDLE.
REQ-027 At inflight==MAX_INFLIGHT, no grant SHALL occur. A done in that cycle SHALL free a slot, so a grant becomes possible the next cycle.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 On reset, all of the following SHALL be 0: inflight, ScaleValid, gnt0, gnt1, done0, done1, tag_out, err, x_scale, y_scale, z_scale, k_in, InsTagScaleOut, NatLogFlagScaleOut.
REQ-030 On reset, state SHALL be IDLE, idle SHALL be 1, and the owner FIFO SHALL be empty.
REQ-031 Reset mid-operation SHALL discard all outstanding entries. A later done for a pre-reset operation SHALL set err.

Structure
REQ-032 Package descale_ctrl_pkg SHALL hold the state enum, the MAX_INFLIGHT default and the tag width (8).
REQ-033 Sub-module owner_fifo SHALL hold {owner, tag} entries with push, pop, full, empty and head outputs.

Verification
REQ-034 req0 alone with tag 0x11 -> gnt0 at T, ScaleValid at T+1; done at T+5 -> done0 at T+6 with tag_out 0x11; idle returns to 1.
REQ-035 req0 and req1 held continuously -> grants alternate 0,1,0,1 starting with 0; completions route to matching owners in order.
REQ-036 Issue 8 with no done -> inflight=8 and gnt held low; one done -> inflight=7 and the next grant is one cycle later.
REQ-037 hold=1 with 3 in flight -> state DRAIN, no grants; 3 dones -> IDLE, inflight=0.
REQ-038 done while empty -> err=1, no done0/done1, err persists until reset.
REQ-039 reset with 4 in flight -> all outputs 0, idle=1; a stale done afterwards -> err=1.
